// File: rtl/vfpu_stream_sequencer.sv
// vfpu_stream_sequencer
//   Sequences one vector FPU job inside the HWPE. A start pulse from the
//   control slave kicks the operand source streams and the result sink stream.
//   The block then joins the two operand streams and issues operand pairs to
//   the FPU, with at most MAX_INFLIGHT pairs outstanding. It counts issued and
//   retired elements, waits for the sink done flag and pulses done_o.
//
// Optional feature (macro VFPU_SEQ_TIMEOUT_EN):
//   A watchdog aborts a job that makes no progress for TIMEOUT_CYCLES cycles
//   in RUN or WAIT_SINK. It sets error_o and finishes the job through DONE.
//   With the macro undefined there is no watchdog.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   clear_i              soft clear, same effect as reset
//   start_i              job start pulse
//   trans_size_i         element count, sampled together with start_i
//   src_req_start_o      req_start pulse to both operand sources
//   sink_req_start_o     req_start pulse to the result sink
//   opa_valid_i          operand A valid
//   opb_valid_i          operand B valid
//   op_ready_o           common ready to both operand streams
//   fpu_valid_o          issue valid to the FPU
//   fpu_ready_i          FPU ready
//   res_valid_i          result valid, FPU to sink
//   res_ready_i          sink ready
//   sink_done_i          sink stream done flag
//   busy_o               high whenever the FSM is not IDLE
//   done_o               one-cycle job done pulse
//   issued_cnt_o         pairs issued in the current job
//   retired_cnt_o        results accepted by the sink in the current job
//   error_o              sticky error flag
//   state_dbg_o          current FSM state, for debug and checkers
//
// Handshake: a transfer happens on a cycle where valid and ready are both high.
// Valid never waits for ready. Here op_ready_o is derived from fpu_valid_o and
// fpu_ready_i, so an operand pair moves only when the FPU accepts it.

module vfpu_stream_sequencer #(
  parameter int CNT_WIDTH      = 32,
  parameter int MAX_INFLIGHT   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] trans_size_i,
  output logic                 src_req_start_o,
  output logic                 sink_req_start_o,
  input  logic                 opa_valid_i,
  input  logic                 opb_valid_i,
  output logic                 op_ready_o,
  output logic                 fpu_valid_o,
  input  logic                 fpu_ready_i,
  input  logic                 res_valid_i,
  input  logic                 res_ready_i,
  input  logic                 sink_done_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] issued_cnt_o,
  output logic [CNT_WIDTH-1:0] retired_cnt_o,
  output logic                 error_o,
  output logic [2:0]           state_dbg_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_RUN       = 3'd2,
    S_WAIT_SINK = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  if (MAX_INFLIGHT < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("vfpu_stream_sequencer: MAX_INFLIGHT and TIMEOUT_CYCLES must be >= 1");
  end

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_size;
  logic [CNT_WIDTH-1:0] r_issued;
  logic [CNT_WIDTH-1:0] r_retired;
  logic                 r_src_req;
  logic                 r_sink_req;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;

  logic [CNT_WIDTH-1:0] w_inflight;
  logic                 w_credit_ok;
  logic                 w_run;
  logic                 w_fpu_valid;
  logic                 w_issue;
  logic                 w_retire;

  // Credit and issue decisions use the registered counters, so a slot freed
  // by a retire only becomes usable in the following cycle.
  assign w_inflight  = r_issued - r_retired;
  assign w_credit_ok = w_inflight < CNT_WIDTH'(MAX_INFLIGHT);
  assign w_run       = (r_state == S_RUN);
  assign w_fpu_valid = w_run & opa_valid_i & opb_valid_i & w_credit_ok & (r_issued < r_size);
  assign w_issue     = w_fpu_valid & fpu_ready_i;
  assign w_retire    = w_run & res_valid_i & res_ready_i;

`ifdef VFPU_SEQ_TIMEOUT_EN
  logic [31:0] r_wd;
  logic        w_progress;
  assign w_progress = w_issue | w_retire | sink_done_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state    <= S_IDLE;
      r_size     <= '0;
      r_issued   <= '0;
      r_retired  <= '0;
      r_src_req  <= 1'b0;
      r_sink_req <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
`ifdef VFPU_SEQ_TIMEOUT_EN
      r_wd       <= '0;
`endif
    end else begin
      r_src_req  <= 1'b0;
      r_sink_req <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_busy <= 1'b1;
            if (trans_size_i != '0) begin
              // Counters and the error flag are cleared on the way into
              // START so they already read zero during the req_start cycle.
              r_size     <= trans_size_i;
              r_issued   <= '0;
              r_retired  <= '0;
              r_error    <= 1'b0;
              r_src_req  <= 1'b1;
              r_sink_req <= 1'b1;
              r_state    <= S_START;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_START: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_issue) r_issued <= r_issued + 1'b1;
          if (w_retire) begin
            // A result with nothing in flight is bogus: flag it, do not count it.
            if (r_retired == r_issued) r_error   <= 1'b1;
            else                       r_retired <= r_retired + 1'b1;
          end
          if (sink_done_i && (r_retired != r_size)) r_error <= 1'b1;
          if ((r_issued == r_size) && (r_retired == r_size)) r_state <= S_WAIT_SINK;
        end
        S_WAIT_SINK: begin
          if (sink_done_i) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
`ifdef VFPU_SEQ_TIMEOUT_EN
      // Placed after the case so a timeout overrides the normal transition.
      if ((r_state == S_RUN) || (r_state == S_WAIT_SINK)) begin
        if (w_progress) begin
          r_wd <= '0;
        end else if (r_wd == 32'(TIMEOUT_CYCLES - 1)) begin
          r_wd    <= '0;
          r_error <= 1'b1;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end else begin
          r_wd <= r_wd + 1'b1;
        end
      end else begin
        r_wd <= '0;
      end
`endif
    end
  end

  assign src_req_start_o  = r_src_req;
  assign sink_req_start_o = r_sink_req;
  assign fpu_valid_o      = w_fpu_valid;
  assign op_ready_o       = w_issue;
  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign issued_cnt_o     = r_issued;
  assign retired_cnt_o    = r_retired;
  assign error_o          = r_error;
  assign state_dbg_o      = r_state;

endmodule

// File: tb/tb_vfpu_stream_sequencer.sv
// Testbench for vfpu_stream_sequencer: a per-cycle vector table for one small
// job, then hand-written sequences for full jobs, zero size, credit limit,
// soft clear and error cases. A 3-cycle FPU model feeds results back.

module tb_vfpu_stream_sequencer;

  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_i, clear_i, start_i;
  logic [CW-1:0] trans_size_i;
  logic          src_req_start_o, sink_req_start_o;
  logic          opa_valid_i, opb_valid_i, op_ready_o, fpu_valid_o, fpu_ready_i;
  logic          res_valid_i, res_ready_i, sink_done_i;
  logic          busy_o, done_o, error_o;
  logic [CW-1:0] issued_cnt_o, retired_cnt_o;
  logic [2:0]    state_dbg_o;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  vfpu_stream_sequencer #(.CNT_WIDTH(CW), .MAX_INFLIGHT(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .trans_size_i(trans_size_i), .src_req_start_o(src_req_start_o),
    .sink_req_start_o(sink_req_start_o), .opa_valid_i(opa_valid_i),
    .opb_valid_i(opb_valid_i), .op_ready_o(op_ready_o), .fpu_valid_o(fpu_valid_o),
    .fpu_ready_i(fpu_ready_i), .res_valid_i(res_valid_i), .res_ready_i(res_ready_i),
    .sink_done_i(sink_done_i), .busy_o(busy_o), .done_o(done_o),
    .issued_cnt_o(issued_cnt_o), .retired_cnt_o(retired_cnt_o), .error_o(error_o),
    .state_dbg_o(state_dbg_o)
  );

  // ---------------- FPU model: 3-cycle pipe, results wait for sink ready ----------------
  logic       mdl_clr, mdl_en, res_force;
  logic [2:0] pipe;
  int         pend;

  always @(posedge clk) begin
    if (mdl_clr) begin
      pipe <= '0;
      pend <= 0;
    end else begin
      pipe <= {pipe[1:0], op_ready_o};
      pend <= pend + (pipe[2] ? 1 : 0) - ((mdl_en && pend != 0 && res_ready_i) ? 1 : 0);
    end
  end
  assign res_valid_i = res_force | (mdl_en & (pend != 0));

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    clear_i = 0; start_i = 0; trans_size_i = '0; opa_valid_i = 0; opb_valid_i = 0;
    fpu_ready_i = 0; res_ready_i = 0; sink_done_i = 0; res_force = 0;
  endtask

  task automatic model_reset();
    mdl_clr = 1; step(); mdl_clr = 0;
  endtask

  // Scoreboard check: one comparison, one FAIL line on mismatch.
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       start;
    logic [7:0] size;
    logic       opa, opb, fr, rv, rr, sd;
    logic [6:0] flags;  // {src_req, sink_req, op_ready, fpu_valid, busy, done, error}
    logic [7:0] iss, ret;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(input logic st, input logic [7:0] sz, input logic a, input logic b,
                              input logic fr, input logic rv, input logic rr, input logic sd,
                              input logic [6:0] fl, input logic [7:0] is, input logic [7:0] rt);
    vec_t v;
    v.start = st; v.size = sz; v.opa = a; v.opb = b; v.fr = fr; v.rv = rv; v.rr = rr;
    v.sd = sd; v.flags = fl; v.iss = is; v.ret = rt;
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int src_pulses;
    logic [127:0] act_v, exp_v;

    // size=3 job with opb gaps, an FPU stall and sink back-pressure
    vt[0]  = mk(1, 3, 0, 0, 0, 0, 0, 0, 7'b0000000, 0, 0);
    vt[1]  = mk(0, 0, 1, 1, 1, 0, 0, 0, 7'b1100100, 0, 0);
    vt[2]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 7'b0000100, 0, 0);
    vt[3]  = mk(0, 0, 1, 1, 1, 0, 0, 0, 7'b0011100, 0, 0);
    vt[4]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 7'b0001100, 1, 0);
    vt[5]  = mk(0, 0, 1, 1, 1, 1, 1, 0, 7'b0011100, 1, 0);
    vt[6]  = mk(0, 0, 1, 1, 1, 1, 0, 0, 7'b0011100, 2, 1);
    vt[7]  = mk(0, 0, 1, 1, 1, 1, 1, 0, 7'b0000100, 3, 1);
    vt[8]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 7'b0000100, 3, 2);
    vt[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b0000100, 3, 3);
    vt[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 7'b0000100, 3, 3);
    vt[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b0000110, 3, 3);
    vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 3, 3);

    idle_inputs();
    mdl_clr = 1; mdl_en = 0;
    rst_i = 1;
    repeat (3) step();
    rst_i = 0;
    mdl_clr = 0;
    settle();

    check("reset_outputs",
          {src_req_start_o, sink_req_start_o, op_ready_o, fpu_valid_o, busy_o, done_o, error_o},
          7'b0);
    check("reset_counts", {issued_cnt_o, retired_cnt_o}, 64'd0);

    // ---------------- table run (model disabled, res_valid forced per row) ----------------
    for (int i = 0; i < 13; i++) begin
      if (i != 0) step();
      start_i = vt[i].start; trans_size_i = CW'(vt[i].size);
      opa_valid_i = vt[i].opa; opb_valid_i = vt[i].opb; fpu_ready_i = vt[i].fr;
      res_force = vt[i].rv; res_ready_i = vt[i].rr; sink_done_i = vt[i].sd;
      settle();
      act_v = {src_req_start_o, sink_req_start_o, op_ready_o, fpu_valid_o, busy_o, done_o,
               error_o, issued_cnt_o, retired_cnt_o};
      exp_v = {vt[i].flags, CW'(vt[i].iss), CW'(vt[i].ret)};
      check($sformatf("vec%0d", i), act_v, exp_v);
    end
    step();
    idle_inputs();

    // ---------------- size 8, everything ready, 3-cycle FPU ----------------
    model_reset();
    mdl_en = 1;
    opa_valid_i = 1; opb_valid_i = 1; fpu_ready_i = 1; res_ready_i = 1;
    start_i = 1; trans_size_i = 8;
    step();
    start_i = 0; trans_size_i = 0;
    check("s8_req_start_t1", {src_req_start_o, sink_req_start_o, busy_o}, 3'b111);
    src_pulses = 0;
    for (int k = 0; k < 60 && retired_cnt_o != 8; k++) begin
      step();
      if (src_req_start_o || sink_req_start_o) src_pulses++;
    end
    check("s8_retired", retired_cnt_o, 8);
    check("s8_issued", issued_cnt_o, 8);
    check("s8_single_req_start", src_pulses, 0);
    step();
    sink_done_i = 1;
    settle();
    check("s8_no_early_done", done_o, 0);
    step();
    sink_done_i = 0;
    check("s8_done_after_sink", {done_o, error_o}, 2'b10);
    step();
    check("s8_back_idle", {done_o, busy_o}, 2'b00);
    idle_inputs();

    // ---------------- zero size ----------------
    start_i = 1; trans_size_i = 0;
    step();
    start_i = 0;
    check("zero_done_pulse", {done_o, busy_o, src_req_start_o, sink_req_start_o}, 4'b1100);
    step();
    check("zero_back_idle", {done_o, busy_o, src_req_start_o}, 3'b000);

    // ---------------- credit limit with stalled sink ----------------
    model_reset();
    mdl_en = 1;
    opa_valid_i = 1; opb_valid_i = 1; fpu_ready_i = 1; res_ready_i = 0;
    start_i = 1; trans_size_i = 8;
    step();
    start_i = 0;
    repeat (10) step();
    settle();
    check("credit_issued_cap", issued_cnt_o, 4);
    check("credit_ready_low", {op_ready_o, fpu_valid_o, res_valid_i}, 3'b001);
    res_ready_i = 1;
    settle();
    check("credit_same_cycle", op_ready_o, 0);
    step();
    check("credit_next_cycle", {op_ready_o, retired_cnt_o}, {1'b1, CW'(1)});
    for (int k = 0; k < 60 && retired_cnt_o != 8; k++) step();
    check("credit_retired", {issued_cnt_o, retired_cnt_o}, {CW'(8), CW'(8)});
    step();
    sink_done_i = 1;
    step();
    sink_done_i = 0;
    check("credit_done", {done_o, error_o}, 2'b10);
    step();
    idle_inputs();

    // ---------------- soft clear mid-job ----------------
    model_reset();
    mdl_en = 0;
    opa_valid_i = 1; opb_valid_i = 1; fpu_ready_i = 1;
    start_i = 1; trans_size_i = 8;
    step();
    start_i = 0;
    for (int k = 0; k < 20 && issued_cnt_o != 3; k++) step();
    check("clr_reach_3", issued_cnt_o, 3);
    clear_i = 1;
    step();
    clear_i = 0; opa_valid_i = 0;
    check("clr_state", {busy_o, done_o, issued_cnt_o, retired_cnt_o}, 66'd0);
    step();
    check("clr_no_done", {done_o, busy_o}, 2'b00);
    start_i = 1; trans_size_i = 2;
    step();
    start_i = 0;
    check("clr_restart", {src_req_start_o, busy_o}, 2'b11);
    clear_i = 1;
    step();
    clear_i = 0;
    idle_inputs();

    // ---------------- spurious retire, sticky error, clear on START ----------------
    model_reset();
    mdl_en = 1;
    opa_valid_i = 1; opb_valid_i = 1; fpu_ready_i = 1; res_ready_i = 1;
    start_i = 1; trans_size_i = 4;
    step();
    start_i = 0;
    for (int k = 0; k < 20 && issued_cnt_o != 2; k++) step();
    opa_valid_i = 0;
    for (int k = 0; k < 20 && retired_cnt_o != 2; k++) step();
    step(); step();
    check("spur_setup", {issued_cnt_o, retired_cnt_o, error_o}, {CW'(2), CW'(2), 1'b0});
    res_force = 1;
    step();
    res_force = 0;
    check("spur_error", {error_o, retired_cnt_o}, {1'b1, CW'(2)});
    opa_valid_i = 1;
    for (int k = 0; k < 40 && retired_cnt_o != 4; k++) step();
    check("spur_finish_cnt", retired_cnt_o, 4);
    sink_done_i = 1;
    for (int k = 0; k < 10 && !done_o; k++) step();
    sink_done_i = 0;
    check("spur_sticky_at_done", {done_o, error_o}, 2'b11);
    step();
    start_i = 1; trans_size_i = 1; opa_valid_i = 0;
    step();
    start_i = 0;
    check("spur_cleared_on_start", {error_o, src_req_start_o}, 2'b01);
    step();
    sink_done_i = 1;
    step();
    sink_done_i = 0;
    check("early_sink_done_err", error_o, 1);
    clear_i = 1;
    step();
    clear_i = 0;
    check("clear_drops_error", {error_o, busy_o}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
